// File: rtl/fifo_sb_checker.sv
// fifo_sb_checker: cycle-accurate scoreboard for a synchronous FIFO.
// A reference model tracks the observed FIFO traffic and its outputs are compared one cycle later.
module fifo_sb_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  clear_i,
  input  logic                  stop_on_err_i,
  input  logic [7:0]            chk_mask_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic [DATA_WIDTH-1:0] data_out_i,
  input  logic                  wr_ack_i,
  input  logic                  overflow_i,
  input  logic                  underflow_i,
  input  logic                  full_i,
  input  logic                  almostfull_i,
  input  logic                  empty_i,
  input  logic                  almostempty_i,
  output logic [1:0]            state_o,
  output logic [CNT_WIDTH-1:0]  correct_count_o,
  output logic [CNT_WIDTH-1:0]  error_count_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o,
  output logic                  mismatch_o,
  output logic [7:0]            err_vec_o,
  output logic [7:0]            first_err_vec_o,
  output logic [CNT_WIDTH-1:0]  first_err_cycle_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic          AE_AT_RST = (AE_LEVEL == 0);
  // Flag bits [7:1] follow chk_mask order: ae, empty, af, full, underflow, overflow, wr_ack.
  localparam logic [7:1]    EXP_FLAG_RST = {AE_AT_RST, 1'b1, 5'b00000};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  function automatic logic [3:0] level_flags(input logic [CW-1:0] c);
    return {(c == AE_C), (c == {CW{1'b0}}), (c == AF_C), (c == DEPTH_C)};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + CNT_WIDTH'(1);
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] exp_dout_q, exp_dout_d;
  logic [7:1]            exp_flag_q, exp_flag_d;
  logic                  rstn_skip_q;
  logic                  wr_ok_s, rd_ok_s;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  correct_q, correct_d, error_q, error_d, cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  first_cycle_q, first_cycle_d;
  logic [7:0]            err_vec_q, err_vec_d, first_vec_q, first_vec_d;
  logic                  first_seen_q, first_seen_d;
  logic                  mismatch_q, mismatch_d;

  logic [7:1]            obs_flag_s;
  logic [7:0]            diff_s;
  logic                  cmp_en_s, mism_s;

  // Reference FIFO model next state; a sampled DUT reset clears it.
  always_comb begin
    wr_ok_s    = wr_en_i && (cnt_q < DEPTH_C);
    rd_ok_s    = rd_en_i && (cnt_q != {CW{1'b0}});
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    exp_dout_d = exp_dout_q;
    exp_flag_d = exp_flag_q;
    if (!rst_n_i) begin
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      cnt_d      = {CW{1'b0}};
      exp_dout_d = {DATA_WIDTH{1'b0}};
      exp_flag_d = EXP_FLAG_RST;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok_s) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        exp_dout_d = mem_q[rd_ptr_q];
      end else begin
        rd_ptr_d   = rd_ptr_q;
        exp_dout_d = exp_dout_q;
      end
      if (wr_ok_s && !rd_ok_s) begin
        cnt_d = cnt_q + CW'(1);
      end else if (rd_ok_s && !wr_ok_s) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
      exp_flag_d = {level_flags(cnt_d), (rd_en_i && !rd_ok_s), (wr_en_i && !wr_ok_s), wr_ok_s};
    end
  end

  // Model registers, updated every cycle whatever the run state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      exp_dout_q  <= {DATA_WIDTH{1'b0}};
      exp_flag_q  <= EXP_FLAG_RST;
      rstn_skip_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      exp_dout_q  <= exp_dout_d;
      exp_flag_q  <= exp_flag_d;
      rstn_skip_q <= !rst_n_i;
    end
  end

  // Model storage; contents are only read after being written.
  always_ff @(posedge clk_i) begin
    if (!rst_i && rst_n_i && wr_ok_s) begin
      mem_q[wr_ptr_q] <= data_in_i;
    end
  end

  // Field compare against last cycle's expectation; DUT reset cycle and the one after are skipped.
  always_comb begin
    obs_flag_s = {almostempty_i, empty_i, almostfull_i, full_i, underflow_i, overflow_i, wr_ack_i};
    diff_s     = {(exp_flag_q ^ obs_flag_s), (data_out_i != exp_dout_q)} & chk_mask_i;
    cmp_en_s   = (state_q == RUN) && rst_n_i && !rstn_skip_q;
    mism_s     = cmp_en_s && (diff_s != 8'h00);
  end

  // Run-control FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (clear_i) begin
          state_d = IDLE;
        end else if (stop_i || (mism_s && stop_on_err_i)) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (clear_i) begin
          state_d = IDLE;
        end else begin
          state_d = HALT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating statistics and first-error capture.
  always_comb begin
    correct_d     = correct_q;
    error_d       = error_q;
    cycle_d       = cycle_q;
    err_vec_d     = err_vec_q;
    first_vec_d   = first_vec_q;
    first_cycle_d = first_cycle_q;
    first_seen_d  = first_seen_q;
    mismatch_d    = mism_s;
    if (clear_i) begin
      correct_d     = {CNT_WIDTH{1'b0}};
      error_d       = {CNT_WIDTH{1'b0}};
      cycle_d       = {CNT_WIDTH{1'b0}};
      err_vec_d     = 8'h00;
      first_vec_d   = 8'h00;
      first_cycle_d = {CNT_WIDTH{1'b0}};
      first_seen_d  = 1'b0;
    end else if (state_q == RUN) begin
      cycle_d = sat_inc(cycle_q);
      if (mism_s) begin
        error_d   = sat_inc(error_q);
        err_vec_d = err_vec_q | diff_s;
        if (!first_seen_q) begin
          first_vec_d   = diff_s;
          first_cycle_d = cycle_q;
          first_seen_d  = 1'b1;
        end else begin
          first_seen_d  = first_seen_q;
        end
      end else if (cmp_en_s) begin
        correct_d = sat_inc(correct_q);
      end else begin
        correct_d = correct_q;
      end
    end else begin
      cycle_d = cycle_q;
    end
  end

  // Control and statistics registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      correct_q     <= {CNT_WIDTH{1'b0}};
      error_q       <= {CNT_WIDTH{1'b0}};
      cycle_q       <= {CNT_WIDTH{1'b0}};
      err_vec_q     <= 8'h00;
      first_vec_q   <= 8'h00;
      first_cycle_q <= {CNT_WIDTH{1'b0}};
      first_seen_q  <= 1'b0;
      mismatch_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      correct_q     <= correct_d;
      error_q       <= error_d;
      cycle_q       <= cycle_d;
      err_vec_q     <= err_vec_d;
      first_vec_q   <= first_vec_d;
      first_cycle_q <= first_cycle_d;
      first_seen_q  <= first_seen_d;
      mismatch_q    <= mismatch_d;
    end
  end

  assign state_o           = state_q;
  assign correct_count_o   = correct_q;
  assign error_count_o     = error_q;
  assign cycle_count_o     = cycle_q;
  assign mismatch_o        = mismatch_q;
  assign err_vec_o         = err_vec_q;
  assign first_err_vec_o   = first_vec_q;
  assign first_err_cycle_o = first_cycle_q;

endmodule

// File: doc/fifo_sb_checker.md
FIFO_SB_CHECKER -- requirements
Module: fifo_sb_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 16, FIFO data width checked.
REQ-002 Parameter DEPTH, default 8, FIFO depth modelled; power of two, >=4.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, occupancy at which almostfull is expected.
REQ-004 Parameter AE_LEVEL, default 1, occupancy at which almostempty is expected.
REQ-005 Parameter CNT_WIDTH, default 32, width of the correct/error/cycle counters.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  synchronous, active-high reset of the checker.
REQ-008 start, stop, clear  in  1 each  run control pulses.
REQ-009 stop_on_err  in  1  halt at the first mismatch.
REQ-010 chk_mask  in  8  per-field check enable; bit order: [0] data_out, [1] wr_ack, [2] overflow, [3] underflow, [4] full, [5] almostfull, [6] empty, [7] almostempty.
REQ-011 rst_n, wr_en, rd_en  in  1 each  observed DUT inputs.
REQ-012 data_in  in  DATA_WIDTH  observed DUT input.
REQ-013 data_out  in  DATA_WIDTH  observed DUT output.
REQ-014 wr_ack, overflow, underflow, full, almostfull, empty, almostempty  in  1 each  observed DUT outputs.
REQ-015 state  out  2  FSM state.
REQ-016 correct_count, error_count, cycle_count  out  CNT_WIDTH  counters.
REQ-017 mismatch  out  1  one-cycle pulse on any enabled-field mismatch.
REQ-018 err_vec  out  8  sticky OR of mismatching fields.
REQ-019 first_err_vec  out  8  mismatch fields of the first failing cycle.
REQ-020 first_err_cycle  out  CNT_WIDTH  cycle_count value at the first failing cycle.

Function
REQ-021 The FSM SHALL have states IDLE=0, RUN=1, HALT=2; IDLE->RUN on start; RUN->HALT on stop, or on mismatch when stop_on_err=1; HALT->IDLE on clear; clear in RUN SHALL also go to IDLE.
REQ-022 The reference model (memory DEPTH x DATA_WIDTH, wr_ptr, rd_ptr, count) SHALL update every edge regardless of state.
REQ-023 Model: wr_ok = wr_en && count<DEPTH; rd_ok = rd_en && count>0; both accepted together when neither is blocked.
REQ-024 Write at full with read: read only; read at empty with write: write only.
REQ-025 count SHALL be incremented on wr_ok only, decremented on rd_ok only, and unchanged on both or neither.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 Expected values registered at edge k: wr_ack=wr_ok; overflow=wr_en&&!wr_ok; underflow=rd_en&&!rd_ok; data_out=mem[rd_ptr] on rd_ok, else held.
REQ-028 Expected flags SHALL be derived from the updated count: full=(DEPTH), almostfull=(AF_LEVEL), empty=(0), almostempty=(AE_LEVEL).
REQ-029 At edge k+1, each enabled field SHALL be compared against the expected value from edge k.
REQ-030 A compared cycle with no mismatch SHALL increment correct_count; one with any mismatch SHALL increment error_count once.
REQ-031 On a mismatch, mismatch SHALL pulse, err_vec SHALL accumulate the failing fields, and the first failure SHALL load first_err_vec/first_err_cycle.
REQ-032 Comparison and counting SHALL occur only in RUN; cycle_count SHALL increment every RUN cycle.
REQ-033 rst_n=0 sampled: model pointers, count, and expected outputs SHALL be zeroed, with expected empty=1 (and almostempty=1 if AE_LEVEL=0).
REQ-034 The cycle sampling rst_n=0 and the following cycle SHALL be excluded from comparison and counting.
REQ-035 Counters SHALL saturate at all-ones.
REQ-036 chk_mask=0 SHALL count every RUN cycle as correct.
REQ-037 clear SHALL zero counters, err_vec, first_err_*, and the first-error latch; it SHALL NOT touch the model.

Reset
REQ-038 rst=1 at an edge SHALL force state IDLE and zero all outputs, counters, model pointers, count, and expected values, with expected empty=1.
REQ-039 rst SHALL override start/stop/clear in the same cycle.

Verification
REQ-040 Reset, start, 8 writes 1..8 then 8 reads with a correct DUT -> error_count=0; data_out sequence 1..8; full seen after the 8th write.
REQ-041 Write at full -> expected overflow=1, wr_ack=0, count stays 8; DUT asserting wr_ack=1 -> err_vec=8'h02, error_count=1.
REQ-042 Read at empty -> expected underflow=1; stop_on_err=1 with DUT underflow=0 -> state=HALT, first_err_vec=8'h08.
REQ-043 Simultaneous wr/rd at count=4 -> count stays 4, data ordered; at count=0 -> write only, empty deasserts.
REQ-044 DUT rst_n=0 mid-stream at count=5 -> next compared cycle expects empty=1, no false error; 20 writes exercise pointer wrap.
REQ-045 chk_mask=8'h01 with a corrupted almostfull -> no error; clear in HALT -> IDLE, counters zero.
